alarm_snooze_ctrl: RTL and testbench

Alarm ringing controller for the alarm clock. It compares the counter's current time against the alarm register's time and detects the start of the alarm minute. It then sequences the alarm tone through ringing, snooze and auto-timeout phases. It sits between the counter/alarm register outputs and the display/sound path, replacing a plain match-to-sound decode.

---
 rtl/alarm_snooze_ctrl.sv | 170 +++++++++++++++++
 tb/tb_alarm_snooze_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/alarm_snooze_ctrl.sv
// Alarm ringing controller: detects the start of the alarm minute and sequences ringing, snooze and auto-timeout.
// Optional macro SOUND_PULSE_EN: when defined, the tone beeps 1 s on / 1 s off while ringing.
module alarm_snooze_ctrl #(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_MIN = 5,
  parameter int MAX_SNOOZE = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       one_second,
  input  logic       one_minute,
  input  logic [3:0] current_time_ms_hr,
  input  logic [3:0] current_time_ls_hr,
  input  logic [3:0] current_time_ms_min,
  input  logic [3:0] current_time_ls_min,
  input  logic [3:0] alarm_time_ms_hr,
  input  logic [3:0] alarm_time_ls_hr,
  input  logic [3:0] alarm_time_ms_min,
  input  logic [3:0] alarm_time_ls_min,
  input  logic       alarm_on,
  input  logic       snooze_button,
  input  logic       stop_button,
  output logic       alarm_sound,
  output logic       snooze_active,
  output logic [3:0] snooze_count
);

  typedef enum logic [1:0] {IDLE = 2'd0, RINGING = 2'd1, SNOOZE = 2'd2} state_t;

  state_t     state_r, state_nx_s;
  logic [7:0] ring_tmr_r, ring_tmr_nx_s;
  logic [3:0] snz_tmr_r, snz_tmr_nx_s;
  logic [3:0] snz_cnt_r, snz_cnt_nx_s;
  logic       match_s, match_d_r, trigger_s;
  logic       snz_btn_d_r, stop_btn_d_r, snz_press_s, stop_press_s;
  logic       enter_ring_s, sec_adv_s, sound_nx_s;

  assign match_s = (current_time_ms_hr  == alarm_time_ms_hr)  &&
                   (current_time_ls_hr  == alarm_time_ls_hr)  &&
                   (current_time_ms_min == alarm_time_ms_min) &&
                   (current_time_ls_min == alarm_time_ls_min);
  assign trigger_s    = match_s & ~match_d_r & alarm_on;
  assign snz_press_s  = snooze_button & ~snz_btn_d_r;
  assign stop_press_s = stop_button & ~stop_btn_d_r;
  assign snooze_count = snz_cnt_r;

  // Next-state, timers and snooze count; match_d resets high so equal times at reset release never ring.
  always_comb begin
    state_nx_s    = state_r;
    ring_tmr_nx_s = ring_tmr_r;
    snz_tmr_nx_s  = snz_tmr_r;
    snz_cnt_nx_s  = snz_cnt_r;
    enter_ring_s  = 1'b0;
    sec_adv_s     = 1'b0;
    if (!alarm_on) begin
      state_nx_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (trigger_s) begin
            state_nx_s = RINGING;
            enter_ring_s = 1'b1;
          end else begin
            state_nx_s = IDLE;
          end
        end
        RINGING: begin
          if (stop_press_s) begin
            state_nx_s = IDLE;
          end else if (snz_press_s && (snz_cnt_r < 4'(MAX_SNOOZE))) begin
            state_nx_s   = SNOOZE;
            snz_cnt_nx_s = snz_cnt_r + 4'd1;
            snz_tmr_nx_s = 4'd0;
          end else if (one_second) begin
            if (ring_tmr_r == 8'(RING_SEC - 1)) begin
              state_nx_s = IDLE;
            end else begin
              ring_tmr_nx_s = ring_tmr_r + 8'd1;
              sec_adv_s     = 1'b1;
            end
          end else begin
            state_nx_s = RINGING;
          end
        end
        SNOOZE: begin
          if (stop_press_s) begin
            state_nx_s = IDLE;
          end else if (trigger_s) begin
            state_nx_s   = RINGING;
            enter_ring_s = 1'b1;
          end else if (one_minute) begin
            if (snz_tmr_r == 4'(SNOOZE_MIN - 1)) begin
              state_nx_s   = RINGING;
              enter_ring_s = 1'b1;
            end else begin
              snz_tmr_nx_s = snz_tmr_r + 4'd1;
            end
          end else begin
            state_nx_s = SNOOZE;
          end
        end
        default: state_nx_s = IDLE;
      endcase
    end
    if (enter_ring_s) begin
      ring_tmr_nx_s = 8'd0;
    end else begin
      ring_tmr_nx_s = ring_tmr_nx_s;
    end
    if (state_nx_s == IDLE) begin
      snz_cnt_nx_s = 4'd0;
    end else begin
      snz_cnt_nx_s = snz_cnt_nx_s;
    end
  end

`ifdef SOUND_PULSE_EN
  logic phase_r, phase_nx_s;

  // Beep phase starts on at every ring entry and flips on each second spent ringing.
  always_comb begin
    if (enter_ring_s) begin
      phase_nx_s = 1'b1;
    end else if (sec_adv_s) begin
      phase_nx_s = ~phase_r;
    end else begin
      phase_nx_s = phase_r;
    end
  end

  // Beep phase register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase_r <= 1'b0;
    end else begin
      phase_r <= phase_nx_s;
    end
  end

  assign sound_nx_s = (state_nx_s == RINGING) & phase_nx_s;
`else
  assign sound_nx_s = (state_nx_s == RINGING);
`endif

  // State, timers, edge-detect history and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r       <= IDLE;
      ring_tmr_r    <= 8'd0;
      snz_tmr_r     <= 4'd0;
      snz_cnt_r     <= 4'd0;
      match_d_r     <= 1'b1;
      snz_btn_d_r   <= 1'b0;
      stop_btn_d_r  <= 1'b0;
      alarm_sound   <= 1'b0;
      snooze_active <= 1'b0;
    end else begin
      state_r       <= state_nx_s;
      ring_tmr_r    <= ring_tmr_nx_s;
      snz_tmr_r     <= snz_tmr_nx_s;
      snz_cnt_r     <= snz_cnt_nx_s;
      match_d_r     <= match_s;
      snz_btn_d_r   <= snooze_button;
      stop_btn_d_r  <= stop_button;
      alarm_sound   <= sound_nx_s;
      snooze_active <= (state_nx_s == SNOOZE);
    end
  end

endmodule

// File: tb/tb_alarm_snooze_ctrl.sv
// Bench for alarm_snooze_ctrl: directed vector table, async-reset corner, then random traffic against a countdown model.
module tb_alarm_snooze_ctrl;
  localparam int RING_SEC = 4, SNOOZE_MIN = 2, MAX_SNOOZE = 2;
`ifdef SOUND_PULSE_EN
  localparam bit PULSE = 1'b1;
`else
  localparam bit PULSE = 1'b0;
`endif
  localparam logic [15:0] ALM = 16'h0730;

  logic clock = 1'b0, reset = 1'b0;
  logic one_second = 1'b0, one_minute = 1'b0;
  logic [15:0] cur = 16'h0730, alm = ALM;
  logic alarm_on = 1'b1, snooze_button = 1'b0, stop_button = 1'b0;
  logic alarm_sound, snooze_active;
  logic [3:0] snooze_count;

  int checks = 0, errors = 0;

  always #5 clock = ~clock;

  alarm_snooze_ctrl #(.RING_SEC(RING_SEC), .SNOOZE_MIN(SNOOZE_MIN), .MAX_SNOOZE(MAX_SNOOZE)) dut (
    .clock(clock), .reset(reset), .one_second(one_second), .one_minute(one_minute),
    .current_time_ms_hr(cur[15:12]), .current_time_ls_hr(cur[11:8]),
    .current_time_ms_min(cur[7:4]), .current_time_ls_min(cur[3:0]),
    .alarm_time_ms_hr(alm[15:12]), .alarm_time_ls_hr(alm[11:8]),
    .alarm_time_ms_min(alm[7:4]), .alarm_time_ls_min(alm[3:0]),
    .alarm_on(alarm_on), .snooze_button(snooze_button), .stop_button(stop_button),
    .alarm_sound(alarm_sound), .snooze_active(snooze_active), .snooze_count(snooze_count));

  // Reference model: mode 0 idle, 1 ringing, 2 snoozing; timers count remaining ticks.
  int m_mode, m_ring_left, m_snz_left, m_used;
  bit m_phase, m_prev_match, m_prev_snz, m_prev_stop;

  task automatic model_reset();
    m_mode = 0; m_ring_left = 0; m_snz_left = 0; m_used = 0; m_phase = 1'b0;
    m_prev_match = 1'b1; m_prev_snz = 1'b0; m_prev_stop = 1'b0;
  endtask

  task automatic m_ring();
    m_mode = 1; m_ring_left = RING_SEC; m_phase = 1'b1;
  endtask

  task automatic model_step();
    bit match, trig, sp, tp;
    match = (cur == alm);
    trig  = match && !m_prev_match && alarm_on;
    sp    = snooze_button && !m_prev_snz;
    tp    = stop_button && !m_prev_stop;
    if (!alarm_on) m_mode = 0;
    else if (m_mode == 0) begin
      if (trig) m_ring();
    end else if (m_mode == 1) begin
      if (tp) m_mode = 0;
      else if (sp && m_used < MAX_SNOOZE) begin
        m_used++; m_mode = 2; m_snz_left = SNOOZE_MIN;
      end else if (one_second) begin
        m_ring_left--;
        if (m_ring_left == 0) m_mode = 0;
        else m_phase = !m_phase;
      end
    end else begin
      if (tp) m_mode = 0;
      else if (trig) m_ring();
      else if (one_minute) begin
        m_snz_left--;
        if (m_snz_left == 0) m_ring();
      end
    end
    if (m_mode == 0) m_used = 0;
    m_prev_match = match; m_prev_snz = snooze_button; m_prev_stop = stop_button;
  endtask

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic [15:0] cur;
    logic on, snz, stop, sec, mins;
    logic e_snd, e_snd_p, e_act;
    logic [3:0] e_cnt;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic [15:0] c, input logic on, input logic snz, input logic stp,
                     input logic sec, input logic mins, input logic es, input logic esp,
                     input logic ea, input logic [3:0] ec);
    vec_t v;
    v.cur = c; v.on = on; v.snz = snz; v.stop = stp; v.sec = sec; v.mins = mins;
    v.e_snd = es; v.e_snd_p = esp; v.e_act = ea; v.e_cnt = ec;
    vecs.push_back(v);
  endtask

  initial begin
    logic [15:0] times [6];
    times[0] = 16'h0729; times[1] = 16'h0730; times[2] = 16'h0731;
    times[3] = 16'h0630; times[4] = 16'h1730; times[5] = 16'h0720;

    //   cur       on snz stp sec min snd sndp act cnt
    add(16'h0730, 1, 0, 0, 0, 0, 0, 0, 0, 4'd0);  // equal at reset release: silent
    add(16'h0730, 1, 0, 0, 1, 0, 0, 0, 0, 4'd0);
    add(16'h0729, 1, 0, 0, 0, 0, 0, 0, 0, 4'd0);
    add(16'h0730, 1, 0, 0, 0, 0, 1, 1, 0, 4'd0);  // minute edge triggers
    add(16'h0730, 1, 0, 0, 1, 0, 1, 0, 0, 4'd0);
    add(16'h0730, 1, 0, 0, 1, 0, 1, 1, 0, 4'd0);
    add(16'h0730, 1, 0, 0, 1, 0, 1, 0, 0, 4'd0);
    add(16'h0730, 1, 0, 0, 1, 0, 0, 0, 0, 4'd0);  // 4th tick auto-stops
    add(16'h0730, 1, 0, 0, 0, 0, 0, 0, 0, 4'd0);
    add(16'h0731, 1, 0, 0, 0, 0, 0, 0, 0, 4'd0);
    add(16'h0730, 1, 0, 0, 0, 0, 1, 1, 0, 4'd0);
    add(16'h0730, 1, 1, 0, 0, 0, 0, 0, 1, 4'd1);  // first snooze
    add(16'h0730, 1, 0, 0, 0, 1, 0, 0, 1, 4'd1);
    add(16'h0730, 1, 0, 0, 0, 1, 1, 1, 0, 4'd1);  // re-ring after 2 minutes
    add(16'h0730, 1, 1, 0, 0, 0, 0, 0, 1, 4'd2);
    add(16'h0730, 1, 0, 0, 0, 1, 0, 0, 1, 4'd2);
    add(16'h0730, 1, 0, 0, 0, 1, 1, 1, 0, 4'd2);
    add(16'h0730, 1, 1, 0, 0, 0, 1, 1, 0, 4'd2);  // third press ignored
    add(16'h0730, 1, 0, 0, 1, 0, 1, 0, 0, 4'd2);
    add(16'h0730, 1, 1, 1, 0, 0, 0, 0, 0, 4'd0);  // stop beats snooze
    add(16'h0730, 1, 0, 0, 0, 0, 0, 0, 0, 4'd0);
    add(16'h0731, 1, 0, 0, 0, 0, 0, 0, 0, 4'd0);
    add(16'h0730, 1, 0, 0, 0, 0, 1, 1, 0, 4'd0);
    add(16'h0730, 1, 1, 0, 0, 0, 0, 0, 1, 4'd1);
    add(16'h0730, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0);  // disarm in snooze
    add(16'h0730, 1, 0, 0, 0, 0, 0, 0, 0, 4'd0);  // re-arm while matching: silent

    model_reset();
    #12;
    check("reset_sound", alarm_sound, 0);
    check("reset_active", snooze_active, 0);
    check("reset_count", snooze_count, 0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    foreach (vecs[i]) begin
      cur = vecs[i].cur; alarm_on = vecs[i].on; snooze_button = vecs[i].snz;
      stop_button = vecs[i].stop; one_second = vecs[i].sec; one_minute = vecs[i].mins;
      tick();
      check($sformatf("vec%0d_sound", i), alarm_sound, PULSE ? vecs[i].e_snd_p : vecs[i].e_snd);
      check($sformatf("vec%0d_active", i), snooze_active, vecs[i].e_act);
      check($sformatf("vec%0d_count", i), snooze_count, vecs[i].e_cnt);
    end

    // Async reset mid-ring: outputs drop with no clock edge.
    alarm_on = 1'b1; snooze_button = 1'b0; stop_button = 1'b0;
    one_second = 1'b0; one_minute = 1'b0;
    cur = 16'h0731; tick();
    cur = 16'h0730; tick();
    check("midring_sound", alarm_sound, 1);
    #2 reset = 1'b0;
    #1;
    check("async_reset_sound", alarm_sound, 0);
    check("async_reset_active", snooze_active, 0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) cur = times[$urandom_range(0, 5)];
      alarm_on      = ($urandom_range(0, 31) != 0);
      snooze_button = ($urandom_range(0, 3) == 0);
      stop_button   = ($urandom_range(0, 15) == 0);
      one_second    = ($urandom_range(0, 2) == 0);
      one_minute    = ($urandom_range(0, 3) == 0);
      tick();
      check("rand_sound", alarm_sound, int'(m_mode == 1 && (!PULSE || m_phase)));
      check("rand_active", snooze_active, int'(m_mode == 2));
      check("rand_count", snooze_count, m_used);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
